// File: rtl/sseg_pkg.sv
// Shared segment glyphs for the seven-segment scan controller.
// Patterns are active-low, bit 6 = g ... bit 0 = a.
package sseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // BCD mode shows nothing for 10..15 rather than a misleading letter.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex_mode);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    if (!hex_mode && nib > 4'd9) pat = SEG_BLANK;
    return pat;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Registered nibble-to-cathode decoder with board polarity applied.
module sseg_decode
  import sseg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);

  logic [6:0] polarity;
  assign polarity = ACTIVE_LOW ? 7'b0000000 : 7'b1111111;

  always_ff @(posedge clk) begin
    if (rst) seg <= SEG_BLANK ^ polarity;
    else     seg <= glyph(nibble, hex_mode) ^ polarity;
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaler, digit index, double-buffered
// digit store, leading-zero blanking and PWM brightness gate.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    hex_mode_i,
  input  logic                    lz_blank_i,
  input  logic [3:0]              bright_i,
  output logic [NUM_DIGITS-1:0]   sseg_a_o,
  output logic [6:0]              sseg_c_o,
  output logic                    sseg_dp_o,
  output logic                    frame_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  pend_v;
  logic [DW-1:0]         pend_digits;
  logic [DW-1:0]         disp_digits;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] disp_dp;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lead_zero;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] anode_on;

  assign tick = &div_cnt;
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // lead_zero stays set only while every digit from the left so far is zero.
  always_comb begin
    cur_nibble = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    lead_zero  = lz_blank_i;
    anode_on   = '0;
    pwm_on     = div_cnt[DIV_W-1 -: 4] < bright_i;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lead_zero = lead_zero && (disp_digits[DW-1-4*k -: 4] == 4'd0);
      if (idx == IDX_W'(k)) begin
        cur_nibble = disp_digits[DW-1-4*k -: 4];
        cur_dp     = disp_dp[NUM_DIGITS-1-k];
        cur_blank  = lead_zero && (k != NUM_DIGITS - 1);
        anode_on[NUM_DIGITS-1-k] = pwm_on && !lead_zero_gate(lead_zero, k);
      end
    end
  end

  function automatic logic lead_zero_gate(input logic lz, input int k);
    return lz && (k != NUM_DIGITS - 1);
  endfunction

  // A load racing the wrap lands in pending only, so pend_v must stay set.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      pend_v      <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
      sseg_a_o    <= {NUM_DIGITS{ACTIVE_LOW}};
      sseg_dp_o   <= ACTIVE_LOW;
      frame_o     <= 1'b0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (tick) idx <= wrap ? '0 : idx + IDX_W'(1);
      frame_o <= wrap;
      if (wrap && pend_v) begin
        disp_digits <= pend_digits;
        disp_dp     <= pend_dp;
      end
      if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_i;
        pend_v      <= 1'b1;
      end else if (wrap) begin
        pend_v <= 1'b0;
      end
      sseg_a_o  <= anode_on ^ {NUM_DIGITS{ACTIVE_LOW}};
      sseg_dp_o <= (cur_dp && !cur_blank) ^ ACTIVE_LOW;
    end
  end

  sseg_decode #(
    .ACTIVE_LOW(ACTIVE_LOW)
  ) u_decode (
    .clk      (clk),
    .rst      (rst),
    .nibble   (cur_nibble),
    .hex_mode (hex_mode_i),
    .seg      (sseg_c_o)
  );

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with NUM_DIGITS=4, DIV_W=4, active-low pins.
// cyc counts rising edges since reset release; outputs at cyc=t reflect count t-1.
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        hex_mode_i;
  logic        lz_blank_i;
  logic [3:0]  bright_i;
  logic [3:0]  sseg_a_o;
  logic [6:0]  sseg_c_o;
  logic        sseg_dp_o;
  logic        frame_o;

  int checks;
  int failures;
  int cyc;

  logic [3:0] exp_a [4];
  logic [6:0] exp_c [4];

  sseg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV_W     (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_i  (digits_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .hex_mode_i(hex_mode_i),
    .lz_blank_i(lz_blank_i),
    .bright_i  (bright_i),
    .sseg_a_o  (sseg_a_o),
    .sseg_c_o  (sseg_c_o),
    .sseg_dp_o (sseg_dp_o),
    .frame_o   (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic goTo(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp);
    digits_i = d;
    dp_i     = dp;
    load_i   = 1'b1;
    @(negedge clk);
    cyc++;
    load_i   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ea, input logic [6:0] ec);
    checks++;
    assert (sseg_a_o === ea) else begin
      failures++;
      $error("[TB] FAIL %s anode observed=%b expected=%b (cyc=%0d)", tag, sseg_a_o, ea, cyc);
    end
    checks++;
    assert (sseg_c_o === ec) else begin
      failures++;
      $error("[TB] FAIL %s cathode observed=%b expected=%b (cyc=%0d)", tag, sseg_c_o, ec, cyc);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b (cyc=%0d)", tag, obs, expv, cyc);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    exp_a[0] = 4'b0111; exp_a[1] = 4'b1011; exp_a[2] = 4'b1101; exp_a[3] = 4'b1110;
    exp_c[0] = 7'b1111001; exp_c[1] = 7'b0100100; exp_c[2] = 7'b0110000; exp_c[3] = 7'b0011001;

    rst = 1'b1; digits_i = '0; dp_i = '0; load_i = 1'b0;
    hex_mode_i = 1'b1; lz_blank_i = 1'b0; bright_i = 4'd15;
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset", 4'b1111, 7'b1111111);
    checkBit("reset_dp", sseg_dp_o, 1'b1);
    checkBit("reset_frame", frame_o, 1'b0);

    rst = 1'b0; cyc = 0;
    applyStimulus(16'h1234, 4'b0100);
    goTo(5);  checkOutput("frame0_old_display", 4'b0111, 7'b1000000);
    goTo(63); checkBit("frame_low_before_wrap", frame_o, 1'b0);
    goTo(64); checkBit("frame_pulse_1", frame_o, 1'b1);
    goTo(65); checkBit("frame_one_cycle", frame_o, 1'b0);

    $display("[TB] scan order");
    for (int i = 0; i < 4; i++) begin
      goTo(65 + 16 * i);
      checkOutput("scan_on", exp_a[i], exp_c[i]);
      checkBit("scan_dp", sseg_dp_o, (i == 1) ? 1'b0 : 1'b1);
      goTo(80 + 16 * i);
      checkOutput("scan_gap", 4'b1111, exp_c[i]);
    end
    checkBit("frame_pulse_2", frame_o, 1'b1);

    $display("[TB] leading-zero blanking");
    goTo(130);
    lz_blank_i = 1'b1;
    applyStimulus(16'h0045, 4'b1000);
    goTo(177); checkOutput("tear_free_mid_frame", 4'b1110, 7'b0011001);
    goTo(193); checkOutput("lz_digit0", 4'b1111, 7'b1000000);
    checkBit("lz_dp_suppressed", sseg_dp_o, 1'b1);
    goTo(209); checkOutput("lz_digit1", 4'b1111, 7'b1000000);
    goTo(225); checkOutput("lz_digit2", 4'b1101, 7'b0011001);
    goTo(241); checkOutput("lz_digit3", 4'b1110, 7'b0010010);
    applyStimulus(16'h0000, 4'b0000);
    goTo(257); checkOutput("allzero_digit0", 4'b1111, 7'b1000000);
    goTo(289); checkOutput("allzero_digit2", 4'b1111, 7'b1000000);
    goTo(305); checkOutput("allzero_digit3", 4'b1110, 7'b1000000);

    $display("[TB] tear-free loading");
    goTo(330);
    applyStimulus(16'h9999, 4'b0000);
    goTo(370); checkOutput("load_9999_held", 4'b1110, 7'b1000000);
    goTo(383);
    applyStimulus(16'h5678, 4'b0000);
    checkBit("frame_at_coincident_wrap", frame_o, 1'b1);
    goTo(385); checkOutput("coinc_frame_shows_9999_d0", 4'b0111, 7'b0010000);
    goTo(433); checkOutput("coinc_frame_shows_9999_d3", 4'b1110, 7'b0010000);
    goTo(449); checkOutput("next_frame_5678_d0", 4'b0111, 7'b0010010);
    goTo(497); checkOutput("next_frame_5678_d3", 4'b1110, 7'b0000000);

    $display("[TB] decode mode");
    goTo(460);
    applyStimulus(16'hA123, 4'b0000);
    goTo(513); checkOutput("hex_A", 4'b0111, 7'b0001000);
    goTo(516); hex_mode_i = 1'b0;
    goTo(518); checkOutput("bcd_A_blank", 4'b0111, 7'b1111111);
    hex_mode_i = 1'b1;
    goTo(529); checkOutput("hex_digit1", 4'b1011, 7'b1111001);

    $display("[TB] brightness");
    goTo(570); bright_i = 4'd4;
    goTo(593); checkOutput("bright4_d0", 4'b1011, 7'b1111001);
    goTo(596); checkOutput("bright4_d3", 4'b1011, 7'b1111001);
    goTo(597); checkOutput("bright4_d4", 4'b1111, 7'b1111001);
    goTo(600); bright_i = 4'd0;
    goTo(609); checkOutput("bright0_digit2", 4'b1111, 7'b0100100);
    goTo(625); checkOutput("bright0_digit3", 4'b1111, 7'b0110000);

    $display("[TB] reset mid-slot");
    goTo(645);
    applyStimulus(16'h8888, 4'b1111);
    bright_i = 4'd15; lz_blank_i = 1'b0;
    goTo(650);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset", 4'b1111, 7'b1111111);
    checkBit("midreset_dp", sseg_dp_o, 1'b1);
    checkBit("midreset_frame", frame_o, 1'b0);
    rst = 1'b0; cyc = 0;
    goTo(1);  checkOutput("restart_digit0", 4'b0111, 7'b1000000);
    goTo(17); checkOutput("restart_digit1", 4'b1011, 7'b1000000);
    goTo(64); checkBit("restart_frame", frame_o, 1'b1);
    goTo(65); checkOutput("pending_cleared", 4'b0111, 7'b1000000);
    checkBit("pending_dp_cleared", sseg_dp_o, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
